// File: rtl/sync_prefetch_wconv_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sync_prefetch_wconv_fifo - FWFT FIFO narrowing wide writes into OUT_WIDTH reads.
// Optional rd_level output via SYNC_PREFETCH_WCONV_FIFO_LEVEL_EN.   Rev 1.0
// ============================================================================
module sync_prefetch_wconv_fifo #(
  parameter int OUT_WIDTH    = 32,
  parameter int RATIO        = 2,
  parameter int DEPTH_WIDTH  = 7,
  parameter bit MSB_FIRST    = 1'b0,
  parameter int AFULL_THRESH = 120,
  localparam int WR_WIDTH    = OUT_WIDTH * RATIO,
  localparam int LOG2R       = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wr_en,
  output logic                 wr_vld,
  input  logic [WR_WIDTH-1:0]  wr_data,
  output logic                 wr_afull,
  input  logic                 rd_en,
  output logic                 rd_vld,
  output logic [OUT_WIDTH-1:0] rd_data,
  output logic                 rd_last
`ifdef SYNC_PREFETCH_WCONV_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_WIDTH+LOG2R:0] rd_level
`endif
);

  localparam int DEPTH  = 1 << DEPTH_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? LOG2R : 1;
  localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [DEPTH_WIDTH:0] FULL_OCC  = (DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0] AFULL_OCC = (DEPTH_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [DEPTH_WIDTH:0] PTR_ONE   = (DEPTH_WIDTH + 1)'(1);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    VALID = 1'b1
  } state_t;

  logic [WR_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_WIDTH:0] wr_ptr;
  logic [DEPTH_WIDTH:0] rd_ptr;
  logic [DEPTH_WIDTH:0] occ;
  logic                 full;
  logic                 mem_nempty;
  logic [WR_WIDTH-1:0]  pf;
  logic [LANE_W-1:0]    lane;
  logic                 lane_last;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 load;
  state_t               state;
  state_t               state_nxt;

  assign occ        = wr_ptr - rd_ptr;
  assign full       = (occ == FULL_OCC);
  assign mem_nempty = (occ != '0);
  assign wr_vld     = !rst && !full;
  assign wr_afull   = (occ >= AFULL_OCC);
  assign rd_vld     = (state == VALID);
  assign lane_last  = (lane == LAST_LANE);
  assign rd_last    = rd_vld && lane_last;
  assign wr_acc     = wr_en && wr_vld && !flush;
  assign rd_acc     = rd_en && rd_vld && !flush;
  // Reload on the same edge that consumes the last lane, so streaming has no bubble.
  assign load       = mem_nempty && !flush && ((state == EMPTY) || (rd_acc && lane_last));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (load) state_nxt = VALID;
      VALID: if (rd_acc && lane_last && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pf     <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (load) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        pf     <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[DEPTH_WIDTH-1:0]] <= wr_data;
    end
  end

  generate
    if (RATIO > 1) begin : g_lane
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          lane <= '0;
        end else if (load) begin
          lane <= '0;
        end else if (rd_acc) begin
          lane <= lane + LANE_W'(1);
        end
      end
    end else begin : g_no_lane
      assign lane = '0;
    end
  endgenerate

  generate
    if (RATIO > 1) begin : g_mux
      logic [OUT_WIDTH-1:0] lanes [RATIO];
      logic [LANE_W-1:0]    sel;
      for (genvar i = 0; i < RATIO; i++) begin : g_split
        assign lanes[i] = pf[i*OUT_WIDTH +: OUT_WIDTH];
      end
      assign sel     = MSB_FIRST ? (LAST_LANE - lane) : lane;
      assign rd_data = lanes[sel];
    end else begin : g_pass
      assign rd_data = pf;
    end
  endgenerate

`ifdef SYNC_PREFETCH_WCONV_FIFO_LEVEL_EN
  localparam int LVL_W = DEPTH_WIDTH + 1 + LOG2R;
  // A load just moves RATIO lanes from memory into the prefetch register, so the
  // level only moves on accepted writes (+RATIO) and accepted reads (-1).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_level <= '0;
    end else begin
      rd_level <= rd_level + (wr_acc ? LVL_W'(RATIO) : LVL_W'(0)) - (rd_acc ? LVL_W'(1) : LVL_W'(0));
    end
  end
`endif

endmodule
`default_nettype wire
